srambank_arb_128x4x80: RTL and testbench

SRAMBANK_ARB_128X4X80 -- requirements
Module: srambank_arb_128x4x80

---
 rtl/srambank_arb_128x4x80.sv | 86 ++++++++
 tb/tb_srambank_arb_128x4x80.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/srambank_arb_128x4x80.sv
// srambank_arb_128x4x80: two-port arbiter in front of a single-ported 80-bit SRAM bank.
// Define SRAMBANK_ARB_RDBUF_EN to add per-port read data hold registers.
module srambank_arb_128x4x80 #(
    parameter int PRIO_MODE = 0,
    parameter int AGE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [8:0]  a_addr,
    input  logic [79:0] a_wdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [8:0]  b_addr,
    input  logic [79:0] b_wdata,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic        a_rvalid,
    output logic        b_rvalid,
    output logic [79:0] a_rdata,
    output logic [79:0] b_rdata,
    output logic [8:0]  mem_addr,
    output logic [79:0] mem_wd,
    output logic        mem_banksel,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [79:0] mem_dataout
);
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} own_t;
    logic        ptr_q, ptr_d;
    logic [3:0]  age_q, age_d;
    own_t        own_q, own_d;
    logic [8:0]  addr_q;
    logic [79:0] wd_q;
    logic        force_b, a_win;
    always_comb begin
        force_b     = PRIO_MODE != 0 && b_req && age_q == 4'(AGE_LIMIT);
        a_win       = PRIO_MODE == 0 ? (!b_req || !ptr_q) : !force_b;
        a_gnt       = !reset && a_req && a_win;
        b_gnt       = !reset && b_req && !a_gnt;
        mem_banksel = a_gnt || b_gnt;
        mem_write   = a_gnt ? a_we : (b_gnt && b_we);
        mem_read    = mem_banksel && !mem_write;
        mem_addr    = a_gnt ? a_addr : (b_gnt ? b_addr : addr_q);
        mem_wd      = a_gnt ? a_wdata : (b_gnt ? b_wdata : wd_q);
        ptr_d       = a_gnt ? 1'b1 : (b_gnt ? 1'b0 : ptr_q);
        age_d       = (!b_req || b_gnt) ? 4'd0 : (age_q == 4'd15 ? age_q : age_q + 4'd1);
        own_d       = (a_gnt && !a_we) ? OWN_A : ((b_gnt && !b_we) ? OWN_B : OWN_NONE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= 1'b0;
            age_q  <= 4'd0;
            own_q  <= OWN_NONE;
            addr_q <= 9'd0;
            wd_q   <= 80'd0;
        end else begin
            ptr_q  <= ptr_d;
            age_q  <= age_d;
            own_q  <= own_d;
            addr_q <= mem_addr;
            wd_q   <= mem_wd;
        end
    end
    // Gating with reset kills a read granted just before reset asserts.
    assign a_rvalid = !reset && own_q == OWN_A;
    assign b_rvalid = !reset && own_q == OWN_B;
`ifdef SRAMBANK_ARB_RDBUF_EN
    logic [79:0] a_buf_q, b_buf_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            a_buf_q <= 80'd0;
            b_buf_q <= 80'd0;
        end else begin
            if (a_rvalid) a_buf_q <= mem_dataout;
            if (b_rvalid) b_buf_q <= mem_dataout;
        end
    end
    assign a_rdata = a_rvalid ? mem_dataout : a_buf_q;
    assign b_rdata = b_rvalid ? mem_dataout : b_buf_q;
`else
    assign a_rdata = mem_dataout;
    assign b_rdata = mem_dataout;
`endif
endmodule

// File: tb/tb_srambank_arb_128x4x80.sv
// tb_srambank_arb_128x4x80: round-robin and aging instances under directed and random traffic,
// checked against a behavioural arbitration/SRAM model.
module tb_srambank_arb_128x4x80;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    logic        a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
    logic [8:0]  a_addr = 9'd0, b_addr = 9'd0;
    logic [79:0] a_wdata = 80'd0, b_wdata = 80'd0;
    logic        a_gnt[2], b_gnt[2], a_rv[2], b_rv[2], msel[2], mrd[2], mwr[2];
    logic [8:0]  maddr[2];
    logic [79:0] mwd[2], a_rd[2], b_rd[2], dout[2];
    int n_cmp = 0, n_bad = 0;

    srambank_arb_128x4x80 #(.PRIO_MODE(0)) u_rr (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt[0]), .b_gnt(b_gnt[0]), .a_rvalid(a_rv[0]), .b_rvalid(b_rv[0]),
        .a_rdata(a_rd[0]), .b_rdata(b_rd[0]), .mem_addr(maddr[0]), .mem_wd(mwd[0]),
        .mem_banksel(msel[0]), .mem_read(mrd[0]), .mem_write(mwr[0]), .mem_dataout(dout[0])
    );
    srambank_arb_128x4x80 #(.PRIO_MODE(1), .AGE_LIMIT(3)) u_pr (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt[1]), .b_gnt(b_gnt[1]), .a_rvalid(a_rv[1]), .b_rvalid(b_rv[1]),
        .a_rdata(a_rd[1]), .b_rdata(b_rd[1]), .mem_addr(maddr[1]), .mem_wd(mwd[1]),
        .mem_banksel(msel[1]), .mem_read(mrd[1]), .mem_write(mwr[1]), .mem_dataout(dout[1])
    );

    function automatic logic [79:0] init_val(input logic [8:0] a);
        return {40'hC0FFEE0000, 31'd0, a};
    endfunction

    task automatic chk(input string n, input int k, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %0h want %0h", n, k, $time, act, exp);
        end
    endtask

    // SRAM bank environment: unwritten words read back as init_val(addr)
    bit [79:0] sram[2][512];
    bit        wr[2][512];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (msel[k] && mwr[k]) begin
                sram[k][maddr[k]] <= mwd[k];
                wr[k][maddr[k]]   <= 1'b1;
            end
            if (msel[k] && mrd[k]) dout[k] <= wr[k][maddr[k]] ? sram[k][maddr[k]] : init_val(maddr[k]);
        end
    end

    // Reference model: winner, streak of denied B cycles, pending read, last bus values
    bit [79:0] ref_mem[2][512];
    bit        fav_a[2];
    int        wait_c[2], pend[2];
    bit [79:0] pend_d[2];
    logic [8:0]  la[2];
    logic [79:0] lw[2];
`ifdef SRAMBANK_ARB_RDBUF_EN
    bit [79:0] hold_a[2], hold_b[2];
`endif
    initial begin
        bit ea, eb;
        logic [8:0]  xa;
        logic [79:0] xw;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 512; i++) ref_mem[k][i] = init_val(9'(i));
            fav_a[k] = 1'b1; wait_c[k] = 0; pend[k] = 0; pend_d[k] = '0; la[k] = '0; lw[k] = '0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (k == 0) ea = !reset && a_req && (!b_req || fav_a[k]);
                else        ea = !reset && a_req && !(b_req && wait_c[k] == 3);
                eb = !reset && b_req && !ea;
                xa = ea ? a_addr : (eb ? b_addr : la[k]);
                xw = ea ? a_wdata : (eb ? b_wdata : lw[k]);
                chk("a_gnt", k, a_gnt[k], ea);
                chk("b_gnt", k, b_gnt[k], eb);
                chk("mem_banksel", k, msel[k], ea || eb);
                chk("mem_read", k, mrd[k], (ea && !a_we) || (eb && !b_we));
                chk("mem_write", k, mwr[k], (ea && a_we) || (eb && b_we));
                chk("mem_addr", k, maddr[k], xa);
                chk("mem_wd", k, mwd[k], xw);
                chk("a_rvalid", k, a_rv[k], !reset && pend[k] == 1);
                chk("b_rvalid", k, b_rv[k], !reset && pend[k] == 2);
                if (!reset && pend[k] == 1) chk("a_rdata", k, a_rd[k], pend_d[k]);
                if (!reset && pend[k] == 2) chk("b_rdata", k, b_rd[k], pend_d[k]);
`ifdef SRAMBANK_ARB_RDBUF_EN
                if (!reset) begin
                    if (pend[k] == 1) hold_a[k] = pend_d[k];
                    if (pend[k] == 2) hold_b[k] = pend_d[k];
                    chk("a_rdata_hold", k, a_rd[k], hold_a[k]);
                    chk("b_rdata_hold", k, b_rd[k], hold_b[k]);
                end else begin
                    hold_a[k] = '0; hold_b[k] = '0;
                end
`else
                chk("a_rdata_raw", k, a_rd[k], dout[k]);
                chk("b_rdata_raw", k, b_rd[k], dout[k]);
`endif
                if (reset) begin
                    fav_a[k] = 1'b1; wait_c[k] = 0; pend[k] = 0; la[k] = '0; lw[k] = '0;
                end else begin
                    if (ea) fav_a[k] = 1'b0;
                    if (eb) fav_a[k] = 1'b1;
                    wait_c[k] = (!b_req || eb) ? 0 : (wait_c[k] < 15 ? wait_c[k] + 1 : 15);
                    pend[k] = (ea && !a_we) ? 1 : ((eb && !b_we) ? 2 : 0);
                    if (ea || eb) begin
                        la[k] = xa; lw[k] = xw;
                        if (mrd[k] === 1'b1 || (ea && !a_we) || (eb && !b_we)) pend_d[k] = ref_mem[k][xa];
                        if ((ea && a_we) || (eb && b_we)) ref_mem[k][xa] = xw;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        // Read of 0x005 straight out of reset
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'h005;
        @(negedge clk);
        chk("t_rd_gnt", 0, a_gnt[0], 1'b1);
        chk("t_rd_mread", 0, mrd[0], 1'b1);
        chk("t_rd_maddr", 0, maddr[0], 9'h005);
        step();
        a_req = 1'b0;
        @(negedge clk);
        chk("t_rd_rvalid", 0, a_rv[0], 1'b1);
        chk("t_rd_rdata", 0, a_rd[0], 80'hC0FFEE0000_0000000005);
        // Contention: round-robin alternates, aging forces B every fourth cycle
        step();
        do_reset();
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
        a_addr = 9'h010; b_addr = 9'h020; a_wdata = 80'hAAAA; b_wdata = 80'hBBBB;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t_rr_seq", 0, {a_gnt[0], b_gnt[0]}, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk("t_age_seq", 1, {a_gnt[1], b_gnt[1]}, (i == 3) ? 2'b01 : 2'b10);
            step();
        end
        // A writes 0x1234 to 0x1FF, B reads it back
        b_req = 1'b0; a_req = 1'b1; a_we = 1'b1; a_addr = 9'h1FF; a_wdata = 80'h1234;
        step();
        a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 9'h1FF;
        step();
        b_req = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("t_wr_rd_rvalid", k, b_rv[k], 1'b1);
            chk("t_wr_rd_rdata", k, b_rd[k], 80'h1234);
        end
        // Reset right after a granted read
        step();
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'h005;
        step();
        reset = 1'b1; a_req = 1'b0; b_req = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("t_rst_rvalid", k, a_rv[k], 1'b0);
            chk("t_rst_gnt", k, b_gnt[k], 1'b0);
            chk("t_rst_ctl", k, {msel[k], mrd[k], mwr[k]}, 3'b000);
        end
        step();
        reset = 1'b0; b_req = 1'b0;
`ifdef SRAMBANK_ARB_RDBUF_EN
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'h007;
        step();
        a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 9'h008;
        step();
        b_req = 1'b0;
        step();
        @(negedge clk);
        chk("t_buf_a", 0, a_rd[0], 80'hC0FFEE0000_0000000007);
        chk("t_buf_b", 0, b_rd[0], 80'hC0FFEE0000_0000000008);
`endif
        repeat (4000) begin
            step();
            reset   = $urandom_range(0, 199) == 0;
            a_req   = $urandom_range(0, 2) != 0;
            b_req   = $urandom_range(0, 2) != 0;
            a_we    = $urandom_range(0, 1) == 1;
            b_we    = $urandom_range(0, 1) == 1;
            a_addr  = $urandom_range(0, 3) == 0 ? 9'h1FF : 9'($urandom_range(0, 15));
            b_addr  = $urandom_range(0, 3) == 0 ? 9'h1FF : 9'($urandom_range(0, 15));
            a_wdata = {$urandom, $urandom, 16'($urandom)};
            b_wdata = {$urandom, $urandom, 16'($urandom)};
        end
        step();
        reset = 1'b0; a_req = 1'b0; b_req = 1'b0;
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
